// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Steps through neighbouring register pairs (rs1, rs1+1) of an external
//   register file. For each pair it waits (timed or single-stepped), fetches
//   both operands, runs them through an external ALU and writes the result
//   back into the upper register of the pair. The operation is chosen from
//   the low two bits of rs1. A pass covers all NUM_REGS pairs and can
//   optionally repeat.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        launch pulse, only honoured in IDLE
//   halt_i         synchronous abort back to IDLE
//   loop_en_i      1 = start a new pass after the last pair, 0 = stop
//   step_mode_i    1 = leave WAIT on step_i instead of the delay counter
//   step_i         single-step advance pulse
//   rd_data1_i     register file read data for rs1_o
//   rd_data2_i     register file read data for rs2_o
//   alu_result_i   external ALU result for alu_a_o/alu_b_o/alu_op_o
//   rs1_o, rs2_o   register file read addresses
//   rd_o           register file write address (always equal to rs2_o)
//   alu_a_o        ALU operand A (second fetched operand), zero outside EXEC
//   alu_b_o        ALU operand B (first fetched operand), zero outside EXEC
//   alu_op_o       ALU operation code decoded from rs1_o[1:0]
//   reg_write_o    register file write strobe, high for the WRITE cycle
//   write_data_o   register file write data
//   busy_o         high whenever the sequencer is not IDLE
//   done_o         one-cycle pulse after the last pair of a pass
//   op_count_o     completed operations, wraps at 2^32
// ----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DELAY    = 100000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              halt_i,
  input  logic              loop_en_i,
  input  logic              step_mode_i,
  input  logic              step_i,
  input  logic [XLEN-1:0]   rd_data1_i,
  input  logic [XLEN-1:0]   rd_data2_i,
  input  logic [XLEN-1:0]   alu_result_i,
  output logic [ADDR_W-1:0] rs1_o,
  output logic [ADDR_W-1:0] rs2_o,
  output logic [ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  output logic [3:0]        alu_op_o,
  output logic              reg_write_o,
  output logic [XLEN-1:0]   write_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       op_count_o
);

  // The counter only ever holds values 0 .. DELAY-1.
  localparam int unsigned       CNT_W    = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DELAY - 1);
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_EXEC,
    S_WRITE,
    S_NEXT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [XLEN-1:0]   writeData_q, writeData_d;
  logic [31:0]       opCount_q, opCount_d;
  logic              done_q, done_d;

  logic              lastReg;
  logic              waitExit;
  logic [1:0]        opSel;

  assign lastReg = (rs1_q == LAST_REG);

  // In auto mode the counter reads 0 in the DELAY-th WAIT cycle; in step
  // mode the counter is frozen and only the step pulse matters.
  assign waitExit = step_mode_i ? step_i : (cnt_q == '0);

  // With only two registers there is a single address bit; the upper
  // select bit is then zero so only add and sub are ever used.
  if (ADDR_W >= 2) begin : g_sel_wide
    assign opSel = rs1_q[1:0];
  end else begin : g_sel_narrow
    assign opSel = {1'b0, rs1_q[0]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rs1_d       = rs1_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    writeData_d = writeData_q;
    opCount_d   = opCount_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !halt_i) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end

      S_WAIT: begin
        if (halt_i) begin
          state_d = S_IDLE;
        end else if (waitExit) begin
          state_d = S_FETCH;
        end else if (!step_mode_i) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FETCH: begin
        if (halt_i) begin
          state_d = S_IDLE;
        end else begin
          op1_d   = rd_data1_i;
          op2_d   = rd_data2_i;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (halt_i) begin
          state_d = S_IDLE;
        end else begin
          writeData_d = alu_result_i;
          state_d     = S_WRITE;
        end
      end

      // The write strobe is decoded from this state, so a halt here still
      // lets the write land at the closing edge.
      S_WRITE: begin
        state_d = halt_i ? S_IDLE : S_NEXT;
      end

      // A halt here abandons the bookkeeping: no increment, no done pulse.
      S_NEXT: begin
        if (halt_i) begin
          state_d = S_IDLE;
        end else begin
          opCount_d = opCount_q + 32'd1;
          rs1_d     = rs1_q + ONE_ADDR;
          if (lastReg) begin
            done_d = 1'b1;
            if (loop_en_i) begin
              state_d = S_WAIT;
              cnt_d   = CNT_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rs1_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      writeData_q <= '0;
      opCount_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs1_q       <= rs1_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      writeData_q <= writeData_d;
      opCount_q   <= opCount_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    alu_op_o = 4'b0010;
    case (opSel)
      2'd0:    alu_op_o = 4'b0010;
      2'd1:    alu_op_o = 4'b0110;
      2'd2:    alu_op_o = 4'b0000;
      2'd3:    alu_op_o = 4'b0001;
      default: alu_op_o = 4'b0010;
    endcase
  end

  // Operands are deliberately crossed: A takes the rs2 operand, B the rs1
  // operand, so sub computes reg[rs2] - reg[rs1].
  assign alu_a_o      = (state_q == S_EXEC) ? op2_q : '0;
  assign alu_b_o      = (state_q == S_EXEC) ? op1_q : '0;

  assign rs1_o        = rs1_q;
  assign rs2_o        = rs1_q + ONE_ADDR;
  assign rd_o         = rs1_q + ONE_ADDR;
  assign reg_write_o  = (state_q == S_WRITE);
  assign write_data_o = writeData_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign op_count_o   = opCount_q;

endmodule
